apu_i2s_transmitter: RTL and testbench

// - Consumer end of the APU mixer output: takes the 16-bit mixed sample stream (one value per clock)
//   and box-filter decimates it to one sample per audio frame.
// - Converts the frame average to signed 16-bit PCM and transmits it as a standard I2S mono stream
//   (same word in both slots) to an external audio DAC.

---
 rtl/apu_audio_pkg.sv | 12 +
 rtl/apu_frame_decimator.sv | 50 +++++
 rtl/apu_i2s_transmitter.sv | 85 ++++++++
 tb/tb_apu_i2s_transmitter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/apu_audio_pkg.sv
// Shared constants and helpers for the APU audio output path.
package apu_audio_pkg;

   localparam int I2S_SLOTS = 32;
   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] PCM_OFFSET = 16'h8000;

   function automatic logic [WORD_W-1:0] sat16(input logic [31:0] scaled);
      return (scaled > 32'h0000_FFFF) ? 16'hFFFF : scaled[WORD_W-1:0];
   endfunction

endpackage

// File: rtl/apu_frame_decimator.sv
// Box-filter decimator: averages one frame of mixer samples, applies gain,
// saturates and converts to two's-complement PCM.
module apu_frame_decimator
   import apu_audio_pkg::*;
#(
   parameter int FRAME_LOG2 = 9,
   parameter int GAIN_SHIFT = 5
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic [WORD_W-1:0] iData,
   input  logic              iEnable,
   input  logic              iTerminal,
   output logic [WORD_W-1:0] oNextSample,
   output logic [WORD_W-1:0] oSample,
   output logic              oSampleStrobe
);

   localparam int ACC_W = WORD_W + FRAME_LOG2;

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum;
   logic [WORD_W-1:0] contrib;
   logic [WORD_W-1:0] avg;
   logic [31:0]       scaled;

   assign contrib     = iEnable ? iData : '0;
   assign sum         = acc + ACC_W'(contrib);
   assign avg         = sum[ACC_W-1:FRAME_LOG2];
   assign scaled      = 32'(avg) << GAIN_SHIFT;
   // Combinational word so the serializer can load it on the terminal edge.
   assign oNextSample = sat16(scaled) ^ PCM_OFFSET;

   always_ff @(posedge iClk) begin
      if (iReset) begin
         acc           <= '0;
         oSample       <= '0;
         oSampleStrobe <= 1'b0;
      end else begin
         oSampleStrobe <= iTerminal;
         if (iTerminal) begin
            acc     <= '0;
            oSample <= oNextSample;
         end else begin
            acc <= sum;
         end
      end
   end

endmodule

// File: rtl/apu_i2s_transmitter.sv
// I2S mono transmitter: frame timing, BCLK/LRCK generation and the serializer,
// fed by the frame decimator.
module apu_i2s_transmitter
   import apu_audio_pkg::*;
#(
   parameter int CLK_DIV_LOG2 = 3,
   parameter int GAIN_SHIFT   = 5
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic [WORD_W-1:0] iData,
   input  logic              iEnable,
   output logic              oBCLK,
   output logic              oLRCK,
   output logic              oSDATA,
   output logic [WORD_W-1:0] oSample,
   output logic              oSampleStrobe
);

   localparam int FRAME_LOG2 = CLK_DIV_LOG2 + 6;
   localparam int HB_W       = CLK_DIV_LOG2 + 1;
   localparam int SLOT_W     = FRAME_LOG2 - HB_W;
   localparam int CLK_DIV    = 1 << CLK_DIV_LOG2;

   logic [FRAME_LOG2-1:0] fc;
   logic [FRAME_LOG2-1:0] fcNext;
   logic [HB_W-1:0]       hb;
   logic [SLOT_W-1:0]     nextSlot;
   logic                  terminal;
   logic                  riseEvt;
   logic                  fallEvt;
   logic [2*WORD_W-1:0]   shiftReg;
   logic                  heldLsb;
   logic [WORD_W-1:0]     nextSample;

   assign fcNext   = fc + 1'b1;
   assign hb       = fc[HB_W-1:0];
   assign nextSlot = fcNext[FRAME_LOG2-1:HB_W];
   assign terminal = &fc;
   assign riseEvt  = (hb == HB_W'(CLK_DIV - 1));
   assign fallEvt  = &hb;

   apu_frame_decimator #(
      .FRAME_LOG2(FRAME_LOG2),
      .GAIN_SHIFT(GAIN_SHIFT)
   ) uDecimator (
      .iClk         (iClk),
      .iReset       (iReset),
      .iData        (iData),
      .iEnable      (iEnable),
      .iTerminal    (terminal),
      .oNextSample  (nextSample),
      .oSample      (oSample),
      .oSampleStrobe(oSampleStrobe)
   );

   always_ff @(posedge iClk) begin
      if (iReset) begin
         fc       <= '0;
         oBCLK    <= 1'b0;
         oLRCK    <= 1'b0;
         oSDATA   <= 1'b0;
         shiftReg <= '0;
         heldLsb  <= 1'b0;
      end else begin
         fc <= fcNext;
         if (riseEvt) oBCLK <= 1'b1;
         if (fallEvt) begin
            oBCLK <= 1'b0;
            oLRCK <= (nextSlot >= SLOT_W'(I2S_SLOTS / 2));
         end
         // The terminal cycle is also a falling event; loading wins and slot 0
         // carries the outgoing word's LSB (one-bit I2S delay).
         if (terminal) begin
            shiftReg <= {nextSample, nextSample};
            oSDATA   <= heldLsb;
            heldLsb  <= nextSample[0];
         end else if (fallEvt) begin
            oSDATA   <= shiftReg[2*WORD_W-1];
            shiftReg <= {shiftReg[2*WORD_W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_apu_i2s_transmitter.sv
// Scoreboard bench for apu_i2s_transmitter: strobed samples and the I2S serial stream.
module tb_apu_i2s_transmitter;

   logic        iClk = 1'b0;
   logic        iReset = 1'b1;
   logic [15:0] iData = '0;
   logic        iEnable = 1'b0;
   logic        oBCLK, oLRCK, oSDATA, oSampleStrobe;
   logic [15:0] oSample;

   int checks = 0;
   int errors = 0;
   logic [15:0] expQ[$];
   logic [15:0] serQ[$];
   bit armed = 1'b0;

   always #5 iClk = ~iClk;

   apu_i2s_transmitter dut (
      .iClk         (iClk),
      .iReset       (iReset),
      .iData        (iData),
      .iEnable      (iEnable),
      .oBCLK        (oBCLK),
      .oLRCK        (oLRCK),
      .oSDATA       (oSDATA),
      .oSample      (oSample),
      .oSampleStrobe(oSampleStrobe)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // mode 0: constant, 1: alternating 0/d, 2: iEnable low for first half
   task automatic runFrame(input logic [15:0] d, input int mode, input logic [15:0] req);
      expQ.push_back(req);
      serQ.push_back(req);
      for (int i = 0; i < 512; i++) begin
         @(negedge iClk);
         iReset  = 1'b0;
         armed   = 1'b1;
         iData   = (mode == 1 && i[0] == 1'b0) ? 16'd0 : d;
         iEnable = !(mode == 2 && i < 256);
      end
   endtask

   initial begin
      repeat (2) @(negedge iClk);
      iReset = 1'b0;
      iData = 16'd4000;
      iEnable = 1'b1;
      repeat (712) @(negedge iClk);
      iReset = 1'b1;
      repeat (2) @(negedge iClk);
      check("reset_outputs", {12'b0, oBCLK, oLRCK, oSDATA, oSampleStrobe, oSample}, 32'h0);
      serQ.push_back(16'h0000);
      runFrame(16'd0,    0, 16'h8000);
      runFrame(16'd0,    0, 16'h8000);
      runFrame(16'd1151, 0, 16'h0FE0);
      runFrame(16'd2047, 0, 16'h7FE0);
      runFrame(16'd4000, 0, 16'h7FFF);
      runFrame(16'd1000, 1, 16'hBE80);
      runFrame(16'd1000, 2, 16'hBE80);
      runFrame(16'd2048, 0, 16'h7FFF);
      runFrame(16'd0,    0, 16'h8000);
      runFrame(16'd0,    0, 16'h8000);
      repeat (3) @(negedge iClk);
      check("strobes_outstanding", expQ.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Strobe monitor: sample value, strobe spacing, first BCLK rise.
   initial begin
      int cyc;
      int lastStb;
      bit seenRise;
      cyc = 0;
      lastStb = 0;
      seenRise = 1'b0;
      wait (armed);
      forever begin
         @(negedge iClk);
         cyc++;
         if (!seenRise && oBCLK) begin
            seenRise = 1'b1;
            check("bclk_first_rise", cyc, 32'd8);
         end
         if (oSampleStrobe) begin
            check("strobe_period", cyc - lastStb, 32'd512);
            lastStb = cyc;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL strobe_unexpected actual=%h required=none", oSample);
            end else begin
               check("sample", oSample, expQ.pop_front());
            end
         end
      end
   end

   // Serial monitor: capture 32 slots per frame on BCLK rising edges.
   initial begin
      logic [31:0] lr, sd;
      logic [15:0] cur, prev, leftW;
      logic [14:0] savedRight;
      prev = '0;
      savedRight = '0;
      wait (armed);
      forever begin
         for (int s = 0; s < 32; s++) begin
            @(posedge oBCLK);
            #1;
            lr[s] = oLRCK;
            sd[s] = oSDATA;
         end
         cur = '0;
         if (serQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ser_queue actual=empty required=word");
         end else begin
            cur = serQ.pop_front();
         end
         check("ser_right", {savedRight, sd[0]}, prev);
         check("ser_lrck", lr, 32'hFFFF_0000);
         for (int k = 0; k < 16; k++) leftW[15-k] = sd[1+k];
         check("ser_left", leftW, cur);
         for (int k = 0; k < 15; k++) savedRight[14-k] = sd[17+k];
         prev = cur;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
